uart_rx_checker: RTL and testbench

//  UART 8N1 receiver plus session checker; the receive-side peer of the TX controller.

---
 rtl/uart_rx_checker.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_rx_checker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_checker.sv
// UART 8N1 receiver with 16x oversampling and a session checker that counts good bytes,
// mismatches against a latched reference byte, and framing errors.
module uart_rx_checker #(
  parameter int unsigned CLKS_PER_TICK = 54,
  parameter int unsigned OVERSAMPLE    = 16
) (
  input  logic       system_clock,
  input  logic       cpu_rst_n,
  input  logic       rx,
  input  logic       arm_push,
  input  logic [1:0] num_bytes_to_recv,
  input  logic [7:0] expected_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [8:0] byte_count,
  output logic [7:0] mismatch_count,
  output logic [7:0] frame_err_count,
  output logic       busy,
  output logic       done,
  output logic       led_toggle
);

  localparam int unsigned TickW   = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(CLKS_PER_TICK - 1);
  localparam logic [3:0] OvsLast = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] OvsMid  = 4'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {RIdle, RStart, RData, RStop} rx_state_e;
  typedef enum logic       {SIdle, SRun}                 sess_state_e;

  // Input synchronisation and arm edge detect
  logic r_rx_meta, r_rx_s;
  logic r_arm_d1, r_arm_d2;
  logic w_arm_evt;

  always_ff @(posedge system_clock or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_arm_d1  <= 1'b0;
      r_arm_d2  <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_arm_d1  <= arm_push;
      r_arm_d2  <= r_arm_d1;
    end
  end

  assign w_arm_evt = r_arm_d1 & ~r_arm_d2;

  // Oversample tick generator
  logic [TickW-1:0] r_tick_cnt;
  logic             w_tick;

  assign w_tick = (r_tick_cnt == TickMax);

  always_ff @(posedge system_clock or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TickW'(1);
    end
  end

  // Receive FSM
  rx_state_e   r_rx_state;
  logic [3:0]  r_ovs;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_frame_err;

  always_ff @(posedge system_clock or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_rx_state  <= RIdle;
      r_ovs       <= 4'd0;
      r_bit       <= 3'd0;
      r_shift     <= 8'd0;
      r_rx_data   <= 8'd0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      unique case (r_rx_state)
        RIdle: begin
          // Start edge is accepted on any cycle; the tick only paces the counting
          if (!r_rx_s) begin
            r_rx_state <= RStart;
            r_ovs      <= 4'd0;
          end
        end
        RStart: begin
          if (w_tick) begin
            if (r_ovs == OvsMid) begin
              r_ovs <= 4'd0;
              r_bit <= 3'd0;
              r_rx_state <= r_rx_s ? RIdle : RData;
            end else begin
              r_ovs <= r_ovs + 4'd1;
            end
          end
        end
        RData: begin
          if (w_tick) begin
            if (r_ovs == OvsLast) begin
              r_ovs          <= 4'd0;
              r_shift[r_bit] <= r_rx_s;
              if (r_bit == 3'd7) begin
                r_rx_state <= RStop;
              end else begin
                r_bit <= r_bit + 3'd1;
              end
            end else begin
              r_ovs <= r_ovs + 4'd1;
            end
          end
        end
        RStop: begin
          if (w_tick) begin
            if (r_ovs == OvsLast) begin
              r_ovs <= 4'd0;
              if (r_rx_s) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
              end else begin
                r_frame_err <= 1'b1;
              end
              // Leave at mid stop bit so an immediately following start bit is caught
              r_rx_state <= RIdle;
            end else begin
              r_ovs <= r_ovs + 4'd1;
            end
          end
        end
        default: r_rx_state <= RIdle;
      endcase
    end
  end

  // Session FSM
  sess_state_e r_sess_state;
  logic [8:0]  r_target;
  logic [7:0]  r_expected;
  logic [8:0]  r_byte_count;
  logic [7:0]  r_mismatch_count;
  logic [7:0]  r_frame_err_count;
  logic        r_busy;
  logic        r_done;
  logic        r_led;
  logic [8:0]  w_byte_next;
  logic [8:0]  w_target_sel;

  assign w_byte_next = r_byte_count + 9'd1;

  always_comb begin
    w_target_sel = 9'd1;
    unique case (num_bytes_to_recv)
      2'b00: w_target_sel = 9'd1;
      2'b01: w_target_sel = 9'd10;
      2'b10: w_target_sel = 9'd128;
      2'b11: w_target_sel = 9'd256;
      default: w_target_sel = 9'd1;
    endcase
  end

  always_ff @(posedge system_clock or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_sess_state      <= SIdle;
      r_target          <= 9'd0;
      r_expected        <= 8'd0;
      r_byte_count      <= 9'd0;
      r_mismatch_count  <= 8'd0;
      r_frame_err_count <= 8'd0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_led             <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_sess_state)
        SIdle: begin
          if (w_arm_evt) begin
            r_target          <= w_target_sel;
            r_expected        <= expected_data;
            r_byte_count      <= 9'd0;
            r_mismatch_count  <= 8'd0;
            r_frame_err_count <= 8'd0;
            r_busy            <= 1'b1;
            r_sess_state      <= SRun;
          end
        end
        SRun: begin
          if (r_rx_valid) begin
            r_byte_count <= w_byte_next;
            r_led        <= ~r_led;
            if ((r_rx_data != r_expected) && (r_mismatch_count != 8'hFF)) begin
              r_mismatch_count <= r_mismatch_count + 8'd1;
            end
            if (w_byte_next == r_target) begin
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
              r_sess_state <= SIdle;
            end
          end
          if (r_frame_err && (r_frame_err_count != 8'hFF)) begin
            r_frame_err_count <= r_frame_err_count + 8'd1;
          end
        end
        default: r_sess_state <= SIdle;
      endcase
    end
  end

  assign rx_data         = r_rx_data;
  assign rx_valid        = r_rx_valid;
  assign frame_err       = r_frame_err;
  assign byte_count      = r_byte_count;
  assign mismatch_count  = r_mismatch_count;
  assign frame_err_count = r_frame_err_count;
  assign busy            = r_busy;
  assign done            = r_done;
  assign led_toggle      = r_led;

endmodule

// File: tb/tb_uart_rx_checker.sv
// Scoreboard bench for uart_rx_checker: frames are driven bit-serially, good bytes are queued
// as expected and popped when rx_valid fires; session counters are checked per scenario.
module tb_uart_rx_checker;

  // One tick per clock keeps the 256-frame session within a short run
  localparam int unsigned CPT      = 1;
  localparam int unsigned BIT_CLKS = 16 * CPT;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       arm_push;
  logic [1:0] num;
  logic [7:0] exp_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic [8:0] byte_count;
  logic [7:0] mismatch_count;
  logic [7:0] frame_err_count;
  logic       busy;
  logic       done;
  logic       led_toggle;

  uart_rx_checker #(
    .CLKS_PER_TICK(CPT),
    .OVERSAMPLE   (16)
  ) dut (
    .system_clock     (clk),
    .cpu_rst_n        (rst_n),
    .rx               (rx),
    .arm_push         (arm_push),
    .num_bytes_to_recv(num),
    .expected_data    (exp_data),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .frame_err        (frame_err),
    .byte_count       (byte_count),
    .mismatch_count   (mismatch_count),
    .frame_err_count  (frame_err_count),
    .busy             (busy),
    .done             (done),
    .led_toggle       (led_toggle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  int n_done   = 0;
  int n_extra  = 0;
  int n_pushed = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, want);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_extra++;
      end else begin
        check_eq("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
    if (frame_err) n_ferr++;
    if (done) n_done++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    if (stop) begin
      exp_q.push_back(d);
      n_pushed++;
    end
    rx = 1'b0;
    idle(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      idle(BIT_CLKS);
    end
    rx = stop;
    idle(BIT_CLKS);
    rx = 1'b1;
  endtask

  task automatic arm(input logic [1:0] n, input logic [7:0] e);
    num      = n;
    exp_data = e;
    arm_push = 1'b1;
    idle(4);
    arm_push = 1'b0;
    idle(2);
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_rx_data"}, 32'(rx_data), 32'h0);
    check_eq({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
    check_eq({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    check_eq({tag, "_byte_count"}, 32'(byte_count), 32'h0);
    check_eq({tag, "_mismatch"}, 32'(mismatch_count), 32'h0);
    check_eq({tag, "_ferr_count"}, 32'(frame_err_count), 32'h0);
    check_eq({tag, "_busy"}, 32'(busy), 32'h0);
    check_eq({tag, "_done"}, 32'(done), 32'h0);
    check_eq({tag, "_led"}, 32'(led_toggle), 32'h0);
  endtask

  int done0, valid0, ferr0;
  logic led0;

  initial begin
    rst_n    = 1'b0;
    rx       = 1'b1;
    arm_push = 1'b0;
    num      = 2'b00;
    exp_data = 8'h00;

    // 1: reset state, idle line
    idle(5);
    check_cleared("reset");
    rst_n = 1'b1;
    idle(1000);
    check_eq("idle_valid", 32'(n_valid), 32'd0);
    check_eq("idle_ferr", 32'(n_ferr), 32'd0);

    // 2: single-byte session
    arm(2'b00, 8'h51);
    check_eq("t2_busy_armed", 32'(busy), 32'd1);
    send_frame(8'h51, 1'b1);
    idle(10);
    check_eq("t2_byte_count", 32'(byte_count), 32'd1);
    check_eq("t2_mismatch", 32'(mismatch_count), 32'd0);
    check_eq("t2_done", 32'(n_done), 32'd1);
    check_eq("t2_busy", 32'(busy), 32'd0);
    check_eq("t2_led", 32'(led_toggle), 32'd1);

    // 3: ten-byte session, fourth byte wrong
    done0 = n_done;
    led0  = led_toggle;
    arm(2'b01, 8'h51);
    check_eq("t3_count_cleared", 32'(byte_count), 32'd0);
    for (int i = 0; i < 10; i++) send_frame((i == 3) ? 8'h50 : 8'h51, 1'b1);
    idle(10);
    check_eq("t3_byte_count", 32'(byte_count), 32'd10);
    check_eq("t3_mismatch", 32'(mismatch_count), 32'd1);
    check_eq("t3_done", 32'(n_done - done0), 32'd1);
    check_eq("t3_led", 32'(led_toggle), 32'(led0));
    check_eq("t3_busy", 32'(busy), 32'd0);

    // 4: short glitch rejected, then a frame outside any session
    valid0 = n_valid;
    ferr0  = n_ferr;
    rx = 1'b0;
    idle(5 * CPT);
    rx = 1'b1;
    idle(3 * BIT_CLKS);
    check_eq("t4_glitch_valid", 32'(n_valid - valid0), 32'd0);
    check_eq("t4_glitch_ferr", 32'(n_ferr - ferr0), 32'd0);
    send_frame(8'h3C, 1'b1);
    idle(10);
    check_eq("t4_after_glitch_valid", 32'(n_valid - valid0), 32'd1);
    check_eq("t4_count_held", 32'(byte_count), 32'd10);

    // 5: framing error in a running session; re-arm while busy is ignored
    arm(2'b01, 8'hA5);
    valid0 = n_valid;
    ferr0  = n_ferr;
    send_frame(8'hA5, 1'b0);
    idle(3 * BIT_CLKS);
    check_eq("t5_ferr_pulse", 32'(n_ferr - ferr0), 32'd1);
    check_eq("t5_no_valid", 32'(n_valid - valid0), 32'd0);
    check_eq("t5_ferr_count", 32'(frame_err_count), 32'd1);
    check_eq("t5_byte_count", 32'(byte_count), 32'd0);
    arm(2'b11, 8'h00);
    send_frame(8'hA5, 1'b1);
    idle(10);
    check_eq("t5_rearm_mismatch", 32'(mismatch_count), 32'd0);
    check_eq("t5_rearm_count", 32'(byte_count), 32'd1);
    check_eq("t5_rearm_busy", 32'(busy), 32'd1);

    // Reset mid-session: no done pulse, everything cleared
    done0 = n_done;
    @(negedge clk);
    rst_n = 1'b0;
    idle(3);
    check_cleared("rst_session");
    rst_n = 1'b1;
    idle(20);
    check_eq("rst_session_done", 32'(n_done - done0), 32'd0);

    // 6: 256 back-to-back frames, every one differs from the reference
    done0 = n_done;
    arm(2'b11, 8'h00);
    for (int i = 0; i < 256; i++) send_frame(8'(i) | 8'h01, 1'b1);
    idle(10);
    check_eq("t6_byte_count", 32'(byte_count), 32'd256);
    check_eq("t6_mismatch_sat", 32'(mismatch_count), 32'd255);
    check_eq("t6_done", 32'(n_done - done0), 32'd1);
    check_eq("t6_busy", 32'(busy), 32'd0);

    // Reset in the middle of a frame, then receive cleanly
    done0 = n_done;
    rx = 1'b0;
    idle(BIT_CLKS * 4);
    rst_n = 1'b0;
    rx    = 1'b1;
    idle(3);
    check_cleared("rst_frame");
    rst_n = 1'b1;
    idle(40);
    send_frame(8'h96, 1'b1);
    idle(10);
    check_eq("post_rst_data", 32'(rx_data), 32'h96);
    check_eq("post_rst_count", 32'(byte_count), 32'd0);
    check_eq("post_rst_done", 32'(n_done - done0), 32'd0);

    check_eq("sb_valid_total", 32'(n_valid), 32'(n_pushed));
    check_eq("sb_extra", 32'(n_extra), 32'd0);
    check_eq("sb_pending", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
